// File: rtl/reg_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bank_pkg
//  Description : Shared constants and FSM encoding for the register bank
//                that faces the accumulator in the 8-bit datapath.
//  Revision    : 1.0  initial release
// ============================================================================
package reg_bank_pkg;

  localparam int DEF_WIDTH = 8;  // matches the accumulator width
  localparam int DEF_NREGS = 4;  // power of two, at least 2
  localparam int DEF_AW    = 2;  // log2(DEF_NREGS)

  // Store pipeline: IDLE = no write in flight, WPEND = captured address
  // waiting for the accumulator dump data to arrive.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WPEND = 1'b1
  } state_t;

endpackage : reg_bank_pkg
`default_nettype wire

// File: rtl/reg_bank_fwd.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bank_fwd
//  Description : Read-after-write forwarding mux. Selects the in-flight
//                accumulator dump when the read hits the pending store
//                address, otherwise the stored register contents.
//  Revision    : 1.0  initial release
// ============================================================================
module reg_bank_fwd
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW
) (
  input  logic [AW-1:0]    i_pend_addr,
  input  logic [AW-1:0]    i_rd_addr,
  input  logic             i_wr_pending,
  input  logic [WIDTH-1:0] i_reg_rdata,
  input  logic [WIDTH-1:0] i_in_acc,
  output logic [WIDTH-1:0] o_rd_next
);

  logic w_hit;

  // A hit only exists while a store is waiting for its data cycle; the
  // register still holds the old value then, so in_acc is the fresh one.
  assign w_hit     = i_wr_pending && (i_pend_addr == i_rd_addr);
  assign o_rd_next = w_hit ? i_in_acc : i_reg_rdata;

endmodule : reg_bank_fwd
`default_nettype wire

// File: rtl/reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bank
//  Description : General-purpose register file for the accumulator datapath.
//                Stores the accumulator's registered dump one cycle after
//                StoreReg, supports back-to-back stores and forwards the
//                in-flight value to a read of the pending address.
//  Revision    : 1.0  initial release
// ============================================================================
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREGS = DEF_NREGS,
  parameter int AW    = DEF_AW
) (
  input  logic             clk,
  input  logic             reset,      // asynchronous, active-low
  input  logic             StoreReg,
  input  logic [AW-1:0]    RegAddrW,
  input  logic             ReadReg,
  input  logic [AW-1:0]    RegAddrR,
  input  logic [WIDTH-1:0] in_acc,
  output logic [WIDTH-1:0] out_acc,
  output logic             wr_pending
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_pend_addr;
  logic [WIDTH-1:0] r_regs [NREGS];
  logic [WIDTH-1:0] r_out_acc;
  logic [WIDTH-1:0] w_rd_next;
  logic             w_commit;

  assign w_commit   = (r_state == WPEND);
  assign wr_pending = w_commit;
  assign out_acc    = r_out_acc;

  // State register for the store pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Any StoreReg (re)arms WPEND, even while committing the previous store.
  always_comb begin
    w_state_nxt = IDLE;
    if (StoreReg) begin
      w_state_nxt = WPEND;
    end
  end

  // Latch the destination of a newly captured store.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend_addr <= '0;
    end else if (StoreReg) begin
      r_pend_addr <= RegAddrW;
    end
  end

  // Commit the dump data to the address captured on the previous edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit) begin
      r_regs[r_pend_addr] <= in_acc;
    end
  end

  reg_bank_fwd #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_fwd (
    .i_pend_addr  (r_pend_addr),
    .i_rd_addr    (RegAddrR),
    .i_wr_pending (w_commit),
    .i_reg_rdata  (r_regs[RegAddrR]),
    .i_in_acc     (in_acc),
    .o_rd_next    (w_rd_next)
  );

  // Registered read port; holds its value when no read is requested.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_acc <= '0;
    end else if (ReadReg) begin
      r_out_acc <= w_rd_next;
    end
  end

endmodule : reg_bank
`default_nettype wire

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- Multi-entry general-purpose register file that sits opposite the accumulator in the 8-bit datapath.
- Write side: accepts the accumulator's registered dump output and stores it into an addressed register.
- Read side: drives the accumulator's register-input operand.
- Owns the one-cycle dump-to-store pipeline, including back-to-back stores and read-after-write forwarding, so the control unit needs no stall cycles.

Parameters:
- WIDTH, 8, data width; matches the accumulator width.
- NREGS, 4, number of registers; must be a power of two, at least 2.
- AW, 2, address width; equals log2(NREGS).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- StoreReg  in  1  control: the current cycle's accumulator dump goes to register RegAddrW. The control unit asserts DumpAcc in the same cycle.
- RegAddrW  in  AW  destination register for StoreReg.
- ReadReg  in  1  control: load register RegAddrR onto out_acc.
- RegAddrR  in  AW  source register for ReadReg.
- in_acc  in  WIDTH  accumulator registered dump data; valid the cycle after DumpAcc.
- out_acc  out  WIDTH  registered read data to the accumulator's register-input mux.
- wr_pending  out  1  high while a captured store awaits its data cycle (debug/visibility).

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers, out_acc, pend_addr: 0
  - state = IDLE, wr_pending = 0
  - reset asserted mid-store drops the pending write; the target register reads 0 afterwards.
- FSM states: IDLE, WPEND. wr_pending = (state==WPEND).
- Capture: on an edge with StoreReg=1:
  - pend_addr <= RegAddrW, state <= WPEND.
  - Allowed from either state.
- Commit: on an edge with state==WPEND:
  - reg[pend_addr] <= in_acc. This is the accumulator data dumped in the capture cycle.
  - Next state is WPEND if StoreReg=1 in this cycle (back-to-back, new pend_addr captured at the same edge), else IDLE.
- Store latency: StoreReg at cycle T means reg updated at end of T+1; readable by a ReadReg issued in T+2 without forwarding.
- Read:
  - on an edge with ReadReg=1: out_acc <= reg[RegAddrR]; out_acc is valid from the next cycle.
  - with ReadReg=0: out_acc holds its value.
- Forwarding: ReadReg in cycle T+1 with state==WPEND and RegAddrR==pend_addr → out_acc <= in_acc (the in-flight value), not the stale register.
- Back-to-back stores to the same address: the later one wins. Commits occur in order, one per cycle.
- StoreReg and ReadReg in the same cycle are independent.
  - A read of the address being captured (not yet committed) returns the old contents.
- Address arithmetic: unsigned, no wrap logic needed; every AW-bit value is a valid index.
- No combinational path from any input to out_acc or wr_pending.

Decomposition:
- Shared datapath package holds:
  - WIDTH default constant
  - NREGS and AW defaults
  - FSM state encoding: IDLE=1'b0, WPEND=1'b1
- One sub-module is natural: reg_bank_fwd. It is the combinational forwarding comparator/mux:
  - inputs: pend_addr, RegAddrR, wr_pending, reg read data, in_acc
  - output: next out_acc value
- Storage array and FSM stay in reg_bank.

Test Plan:
- Reset mid-operation: store 0x5A to R1, assert reset=0 during the WPEND cycle → wr_pending=0 at once, out_acc=0; after release, read R1 → 0x00.
- Basic store/read: StoreReg, RegAddrW=2 at T, in_acc=0x3C at T+1; ReadReg, RegAddrR=2 at T+2 → out_acc=0x3C from T+3; wr_pending high only during T+1.
- Forwarding: StoreReg to R3 at T, in_acc=0xA5 at T+1, ReadReg R3 at T+1 → out_acc=0xA5 at T+2; read of R0 at T+1 instead → 0x00.
- Back-to-back stores: StoreReg R0 at T, R1 at T+1, with in_acc=0x11 at T+1 and 0x22 at T+2 → R0=0x11, R1=0x22, wr_pending high T+1..T+2, IDLE at T+3.
- Same-address overwrite plus hold: stores 0x01 then 0xFF to R2 back-to-back → R2=0xFF; with ReadReg=0 for 5 cycles, out_acc is unchanged.
- Simultaneous StoreReg and ReadReg: R1 previously 0x44; StoreReg R1 and ReadReg R1 in the same cycle T, in_acc=0x99 at T+1 → out_acc=0x44 at T+1; ReadReg R1 at T+2 → 0x99.
